// File: rtl/usb_out_cmd_decoder.sv
// Framed command decoder for the CDC OUT byte stream: A5, CMD, ARG, CMD^ARG drives a registered output port.
// Defining USB_OUT_CMD_TIMEOUT_EN adds a mid-frame inactivity timeout that abandons a stalled frame.
module usb_out_cmd_decoder #(
    parameter int unsigned NUM_OUTPUTS    = 8,
    parameter logic [15:0] PULSE_CYCLES   = 16'd12000,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd48000
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   usb_configured_i,
    input  logic [7:0]             out_data_i,
    input  logic                   out_valid_i,
    output logic                   out_ready_o,
    output logic [NUM_OUTPUTS-1:0] outputs_o,
    output logic                   cmd_strobe_o,
    output logic [7:0]             err_count_o,
    output logic                   busy_o
);
    typedef enum logic [1:0] {S_IDLE, S_CMD, S_ARG, S_SUM} state_t;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] CMD_SET   = 8'h01;
    localparam logic [7:0] CMD_OR    = 8'h02;
    localparam logic [7:0] CMD_CLR   = 8'h03;
    localparam logic [7:0] CMD_PULSE = 8'h04;

    state_t                 state_reg;
    logic [7:0]             cmd_reg;
    logic [7:0]             arg_reg;
    logic [7:0]             err_reg;
    logic [NUM_OUTPUTS-1:0] value_reg;
    logic [NUM_OUTPUTS-1:0] pulse_mask_reg;
    logic [NUM_OUTPUTS-1:0] outputs_reg;
    logic [15:0]            pulse_cnt_reg;
    logic                   ready_reg;
    logic                   strobe_reg;

    logic                   accept;
    logic                   cmd_known;
    logic                   sum_ok;
    logic                   execute;
    logic                   frame_err;
    logic                   timeout_hit;
    logic [NUM_OUTPUTS-1:0] arg_bits;
    logic [NUM_OUTPUTS-1:0] value_next;
    logic [NUM_OUTPUTS-1:0] pulse_mask_next;
    logic [15:0]            pulse_cnt_next;
    logic [7:0]             err_next;

    // Only the low NUM_OUTPUTS bits of ARG reach the output registers.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_OUTPUTS; gi++) begin : g_arg_bits
            assign arg_bits[gi] = arg_reg[gi];
        end
    endgenerate

    assign accept    = out_valid_i & ready_reg;
    assign cmd_known = (out_data_i >= CMD_SET) && (out_data_i <= CMD_PULSE);
    assign sum_ok    = (out_data_i == (cmd_reg ^ arg_reg));

    always_comb begin
        execute         = usb_configured_i && accept && (state_reg == S_SUM) && sum_ok;
        frame_err       = timeout_hit ||
                          (usb_configured_i && accept &&
                           (((state_reg == S_CMD) && !cmd_known) ||
                            ((state_reg == S_SUM) && !sum_ok)));
        value_next      = value_reg;
        pulse_cnt_next  = (pulse_cnt_reg != 16'd0) ? pulse_cnt_reg - 16'd1 : 16'd0;
        pulse_mask_next = (pulse_cnt_reg == 16'd1) ? '0 : pulse_mask_reg;
        if (execute) begin
            case (cmd_reg)
                CMD_SET: value_next = arg_bits;
                CMD_OR:  value_next = value_reg | arg_bits;
                CMD_CLR: value_next = value_reg & ~arg_bits;
                default: begin
                    // A PULSE landing on the expiry cycle keeps the old mask and restarts the hold.
                    pulse_mask_next = pulse_mask_reg | arg_bits;
                    pulse_cnt_next  = PULSE_CYCLES;
                end
            endcase
        end
        err_next = (frame_err && (err_reg != 8'hFF)) ? err_reg + 8'd1 : err_reg;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg      <= S_IDLE;
            cmd_reg        <= 8'h00;
            arg_reg        <= 8'h00;
            err_reg        <= 8'h00;
            value_reg      <= '0;
            pulse_mask_reg <= '0;
            outputs_reg    <= '0;
            pulse_cnt_reg  <= 16'd0;
            ready_reg      <= 1'b0;
            strobe_reg     <= 1'b0;
        end else begin
            ready_reg <= 1'b1;
            err_reg   <= err_next;
            if (!usb_configured_i) begin
                // Unconfigured: drain bytes, drop all output state, keep the error history.
                state_reg      <= S_IDLE;
                value_reg      <= '0;
                pulse_mask_reg <= '0;
                outputs_reg    <= '0;
                pulse_cnt_reg  <= 16'd0;
                strobe_reg     <= 1'b0;
            end else begin
                value_reg      <= value_next;
                pulse_mask_reg <= pulse_mask_next;
                pulse_cnt_reg  <= pulse_cnt_next;
                outputs_reg    <= value_next | pulse_mask_next;
                strobe_reg     <= execute;
                if (timeout_hit) begin
                    state_reg <= S_IDLE;
                end else if (accept) begin
                    case (state_reg)
                        S_IDLE: if (out_data_i == SYNC_BYTE) state_reg <= S_CMD;
                        S_CMD: begin
                            if (cmd_known) begin
                                cmd_reg   <= out_data_i;
                                state_reg <= S_ARG;
                            end else begin
                                state_reg <= S_IDLE;
                            end
                        end
                        S_ARG: begin
                            arg_reg   <= out_data_i;
                            state_reg <= S_SUM;
                        end
                        default: state_reg <= S_IDLE;
                    endcase
                end
            end
        end
    end

`ifdef USB_OUT_CMD_TIMEOUT_EN
    logic [15:0] idle_cnt_reg;

    assign timeout_hit = usb_configured_i && !accept && (state_reg != S_IDLE) &&
                         (idle_cnt_reg == TIMEOUT_CYCLES - 16'd1);

    always_ff @(posedge clk_i) begin
        if (rst_i || !usb_configured_i || accept || timeout_hit || (state_reg == S_IDLE)) begin
            idle_cnt_reg <= 16'd0;
        end else begin
            idle_cnt_reg <= idle_cnt_reg + 16'd1;
        end
    end
`else
    // Without the timeout a partial frame waits indefinitely; TIMEOUT_CYCLES has no function.
    localparam logic [15:0] timeout_cycles_unused = TIMEOUT_CYCLES;
    assign timeout_hit = 1'b0;
`endif

    assign out_ready_o  = ready_reg;
    assign outputs_o    = outputs_reg;
    assign cmd_strobe_o = strobe_reg;
    assign err_count_o  = err_reg;
    assign busy_o       = (state_reg != S_IDLE);

endmodule

// File: tb/tb_usb_out_cmd_decoder.sv
// Self-checking bench for usb_out_cmd_decoder: directed frames plus randomized frames against a frame-level model.
module tb_usb_out_cmd_decoder;
    localparam int unsigned NO        = 8;
    localparam logic [15:0] PC        = 16'd16;
    localparam logic [15:0] TC        = 16'd100;
    localparam longint      PULSE_LEN = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic           usb_configured;
    logic [7:0]     out_data;
    logic           out_valid;
    logic           out_ready;
    logic [NO-1:0]  outputs;
    logic           cmd_strobe;
    logic [7:0]     err_count;
    logic           busy;

    int     vectors     = 0;
    int     miscompares = 0;
    longint cyc         = 0;

    // Frame-level reference: value register, pulse mask, cycle of the last PULSE, error count.
    int     r_m        = 0;
    int     p_m        = 0;
    int     err_m      = 0;
    longint last_pulse = -1000;

    usb_out_cmd_decoder #(
        .NUM_OUTPUTS   (NO),
        .PULSE_CYCLES  (PC),
        .TIMEOUT_CYCLES(TC)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .usb_configured_i(usb_configured),
        .out_data_i      (out_data),
        .out_valid_i     (out_valid),
        .out_ready_o     (out_ready),
        .outputs_o       (outputs),
        .cmd_strobe_o    (cmd_strobe),
        .err_count_o     (err_count),
        .busy_o          (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] exp_out();
        int live;
        live = ((cyc - last_pulse) < PULSE_LEN) ? p_m : 0;
        return 8'(r_m | live);
    endfunction

    task automatic model_exec(input logic [7:0] c, input logic [7:0] a);
        case (c)
            8'h01: r_m = int'(a);
            8'h02: r_m = r_m | int'(a);
            8'h03: r_m = r_m & ~int'(a) & 255;
            default: begin
                if (cyc - last_pulse > PULSE_LEN) p_m = 0;
                p_m = p_m | int'(a);
                last_pulse = cyc;
            end
        endcase
    endtask

    task automatic count_err();
        if (err_m < 255) err_m++;
    endtask

    task automatic model_clear();
        r_m = 0;
        p_m = 0;
        last_pulse = -1000;
    endtask

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%02h expected 0x%02h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic idle(input int n);
        out_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                              input logic [7:0] b3, input int n, input int max_gap, input logic busy_exp);
        logic [7:0] f [4];
        f[0] = b0; f[1] = b1; f[2] = b2; f[3] = b3;
        for (int i = 0; i < n; i++) begin
            int g;
            g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
            if (g > 0) begin
                out_valid = 1'b0;
                out_data  = 8'($urandom);
                repeat (g) @(posedge clk);
                #1;
            end
            out_data  = f[i];
            out_valid = 1'b1;
            @(posedge clk);
            #1;
            if (i == 0) check1("busy_after_first_byte", busy, busy_exp);
        end
        out_valid = 1'b0;
    endtask

    task automatic good(input logic [7:0] c, input logic [7:0] a, input int max_gap);
        send_frame(8'hA5, c, a, c ^ a, 4, max_gap, 1'b1);
        model_exec(c, a);
        $display("frame A5 %02h %02h %02h outputs=%02h err=%0d", c, a, c ^ a, outputs, err_count);
        check8("outputs_after_exec", outputs, exp_out());
        check1("strobe_after_exec", cmd_strobe, 1'b1);
        check8("err_after_exec", err_count, 8'(err_m));
        check1("busy_after_exec", busy, 1'b0);
    endtask

    task automatic bad(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                       input logic [7:0] b3, input int n, input int max_gap,
                       input logic busy_exp, input logic counts);
        send_frame(b0, b1, b2, b3, n, max_gap, busy_exp);
        if (counts) count_err();
        $display("reject %0d bytes %02h %02h %02h %02h outputs=%02h err=%0d",
                 n, b0, b1, b2, b3, outputs, err_count);
        check8("outputs_after_reject", outputs, exp_out());
        check1("strobe_after_reject", cmd_strobe, 1'b0);
        check8("err_after_reject", err_count, 8'(err_m));
        check1("busy_after_reject", busy, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] c, a, b;
        int kind;

        rst = 1'b1; usb_configured = 1'b1; out_valid = 1'b0; out_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check1("reset_ready", out_ready, 1'b0);
        check8("reset_outputs", outputs, 8'h00);
        check1("reset_strobe", cmd_strobe, 1'b0);
        check8("reset_err", err_count, 8'h00);
        check1("reset_busy", busy, 1'b0);
        rst = 1'b0;
        idle(1);
        check1("ready_after_reset", out_ready, 1'b1);

        // Basic SET / OR / CLR sequence with valid held high.
        good(8'h01, 8'h3C, 0);
        check8("set_3c", outputs, 8'h3C);
        idle(1);
        check1("strobe_single_pulse", cmd_strobe, 1'b0);
        good(8'h02, 8'h81, 0);
        check8("or_81", outputs, 8'hBD);
        good(8'h03, 8'h0C, 0);
        check8("clr_0c", outputs, 8'hB1);

        // PULSE hold length, restart from a second PULSE, and PULSE on the expiry cycle.
        good(8'h01, 8'h00, 0);
        good(8'h04, 8'h02, 0);
        for (int i = 0; i < 17; i++) begin
            idle(1);
            check8("pulse_hold", outputs, exp_out());
        end
        check8("pulse_expired", outputs, 8'h00);
        good(8'h04, 8'h02, 0);
        idle(6);
        good(8'h04, 8'h01, 0);
        check8("pulse_second", outputs, 8'h03);
        for (int i = 0; i < 17; i++) begin
            idle(1);
            check8("pulse_restart_hold", outputs, exp_out());
        end
        check8("pulse_restart_expired", outputs, 8'h00);
        good(8'h04, 8'h02, 0);
        idle(12);
        good(8'h04, 8'h01, 0);
        check8("pulse_collision", outputs, 8'h03);
        for (int i = 0; i < 17; i++) begin
            idle(1);
            check8("pulse_collision_hold", outputs, exp_out());
        end

        // Rejected frames.
        good(8'h01, 8'h5A, 0);
        bad(8'hA5, 8'h01, 8'h55, 8'h00, 4, 0, 1'b1, 1'b1);
        bad(8'hA5, 8'h07, 8'h00, 8'h00, 2, 0, 1'b1, 1'b1);
        check8("two_bad_frames", err_count, 8'h02);
        bad(8'hA5, 8'hA5, 8'h00, 8'h00, 2, 0, 1'b1, 1'b1);
        good(8'h02, 8'h21, 0);

        // Randomized frames with random inter-byte gaps.
        for (int n = 0; n < 80; n++) begin
            kind = int'($urandom_range(5, 0));
            c = 8'($urandom_range(4, 1));
            a = 8'($urandom);
            case (kind)
                0: begin
                    b = 8'($urandom);
                    if (b == 8'hA5) b = 8'h5A;
                    bad(b, 8'h00, 8'h00, 8'h00, 1, 3, 1'b0, 1'b0);
                end
                1: begin
                    b = 8'($urandom);
                    if (b >= 8'h01 && b <= 8'h04) b = 8'hA5;
                    bad(8'hA5, b, 8'h00, 8'h00, 2, 3, 1'b1, 1'b1);
                end
                2: begin
                    b = c ^ a ^ 8'($urandom_range(255, 1));
                    bad(8'hA5, c, a, b, 4, 3, 1'b1, 1'b1);
                end
                default: good(c, a, 3);
            endcase
        end

        // Losing configuration mid-frame clears outputs and drains bytes.
        good(8'h01, 8'hFF, 0);
        send_frame(8'hA5, 8'h01, 8'h00, 8'h00, 2, 0, 1'b1);
        usb_configured = 1'b0;
        idle(1);
        model_clear();
        check8("unconf_outputs", outputs, 8'h00);
        check1("unconf_busy", busy, 1'b0);
        check8("unconf_err_hold", err_count, 8'(err_m));
        check1("unconf_ready", out_ready, 1'b1);
        bad(8'hA5, 8'h01, 8'h22, 8'h23, 4, 0, 1'b0, 1'b0);
        usb_configured = 1'b1;
        idle(1);
        good(8'h01, 8'h11, 0);
        check8("reconf_set_11", outputs, 8'h11);

        // Error counter saturation.
        for (int n = 0; n < 300; n++) bad(8'hA5, 8'h07, 8'h00, 8'h00, 2, 0, 1'b1, 1'b1);
        check8("err_saturated", err_count, 8'hFF);

`ifdef USB_OUT_CMD_TIMEOUT_EN
        send_frame(8'hA5, 8'h01, 8'h00, 8'h00, 2, 0, 1'b1);
        idle(99);
        check1("timeout_not_yet", busy, 1'b1);
        idle(1);
        count_err();
        check1("timeout_busy", busy, 1'b0);
        check8("timeout_err", err_count, 8'(err_m));
        good(8'h01, 8'h22, 0);
`endif

        // Reset mid-frame discards everything without an error count.
        send_frame(8'hA5, 8'h01, 8'h00, 8'h00, 2, 0, 1'b1);
        rst = 1'b1;
        idle(1);
        model_clear();
        err_m = 0;
        check1("midreset_ready", out_ready, 1'b0);
        check8("midreset_outputs", outputs, 8'h00);
        check1("midreset_busy", busy, 1'b0);
        check8("midreset_err", err_count, 8'h00);
        check1("midreset_strobe", cmd_strobe, 1'b0);
        rst = 1'b0;
        idle(1);
        check1("midreset_ready_back", out_ready, 1'b1);
        good(8'h02, 8'h0F, 0);
        check8("after_reset_or", outputs, 8'h0F);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
